// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: widths, decoded control bundle and its bubble value.
// Imported by the ID/EX register and the load-use detector.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int ALU_OP_W = 4;

  typedef struct packed {
    logic                reg_write;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                reg_dst;
    logic                branch;
    logic                jump_n;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
  } ctrl_t;

  // A bubble must never write state; jump_n and mem_to_reg idle high.
  localparam ctrl_t BUBBLE_CTRL = '{
    reg_write:  1'b0,
    alu_op:     '0,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    branch:     1'b0,
    jump_n:     1'b1,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b1
  };

  function automatic ctrl_t pack_ctrl(
    input logic                reg_write,
    input logic [ALU_OP_W-1:0] alu_op,
    input logic                alu_src,
    input logic                reg_dst,
    input logic                branch,
    input logic                jump_n,
    input logic                mem_read,
    input logic                mem_write,
    input logic                mem_to_reg
  );
    ctrl_t c;
    c.reg_write  = reg_write;
    c.alu_op     = alu_op;
    c.alu_src    = alu_src;
    c.reg_dst    = reg_dst;
    c.branch     = branch;
    c.jump_n     = jump_n;
    c.mem_read   = mem_read;
    c.mem_write  = mem_write;
    c.mem_to_reg = mem_to_reg;
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: purely combinational, zero latency.
// A load in EX whose destination is read by the instruction in ID; r0 never hazards.
module load_use_detect
  import cpu_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic          ex_valid_i,
  input  logic          ex_mem_read_i,
  input  logic [AW-1:0] ex_rt_i,
  input  logic          id_valid_i,
  input  logic [AW-1:0] id_rs_i,
  input  logic [AW-1:0] id_rt_i,
  input  logic          id_uses_rt_i,
  output logic          hazard_o
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (ex_rt_i == id_rs_i);
    rt_match = id_uses_rt_i && (ex_rt_i == id_rt_i);
    hazard_o = ex_valid_i && ex_mem_read_i && (ex_rt_i != '0) && id_valid_i
               && (rs_match || rt_match);
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall/bubble, flush and global hold; 1-cycle latency.
// Optional perf counters under IDEX_PERF_CNT_EN; stall_o asks IF/ID and PC to hold.
module id_ex_stage_reg
  import cpu_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                hold_i,
  input  logic                flush_i,
  input  logic                id_valid_i,
  input  logic                id_reg_write_i,
  input  logic [ALU_OP_W-1:0] id_alu_op_i,
  input  logic                id_alu_src_i,
  input  logic                id_reg_dst_i,
  input  logic                id_branch_i,
  input  logic                id_jump_n_i,
  input  logic                id_mem_read_i,
  input  logic                id_mem_write_i,
  input  logic                id_mem_to_reg_i,
  input  logic [DATA_W-1:0]   id_pc4_i,
  input  logic [DATA_W-1:0]   id_rs_data_i,
  input  logic [DATA_W-1:0]   id_rt_data_i,
  input  logic [DATA_W-1:0]   id_imm_i,
  input  logic [REG_AW-1:0]   id_rs_i,
  input  logic [REG_AW-1:0]   id_rt_i,
  input  logic [REG_AW-1:0]   id_rd_i,
  input  logic                id_uses_rt_i,
  output logic                ex_valid_o,
  output logic                ex_reg_write_o,
  output logic [ALU_OP_W-1:0] ex_alu_op_o,
  output logic                ex_alu_src_o,
  output logic                ex_reg_dst_o,
  output logic                ex_branch_o,
  output logic                ex_jump_n_o,
  output logic                ex_mem_read_o,
  output logic                ex_mem_write_o,
  output logic                ex_mem_to_reg_o,
  output logic [DATA_W-1:0]   ex_pc4_o,
  output logic [DATA_W-1:0]   ex_rs_data_o,
  output logic [DATA_W-1:0]   ex_rt_data_o,
  output logic [DATA_W-1:0]   ex_imm_o,
  output logic [REG_AW-1:0]   ex_rs_o,
  output logic [REG_AW-1:0]   ex_rt_o,
  output logic [REG_AW-1:0]   ex_rd_o,
  output logic                ex_uses_rt_o,
`ifdef IDEX_PERF_CNT_EN
  output logic [15:0]         bubble_cnt_o,
  output logic [15:0]         flush_cnt_o,
`endif
  output logic                stall_o
);

  ctrl_t              ctrl_q, ctrl_d, id_ctrl;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  pc4_q, pc4_d;
  logic [DATA_W-1:0]  rs_data_q, rs_data_d;
  logic [DATA_W-1:0]  rt_data_q, rt_data_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [REG_AW-1:0]  rs_q, rs_d;
  logic [REG_AW-1:0]  rt_q, rt_d;
  logic [REG_AW-1:0]  rd_q, rd_d;
  logic               uses_rt_q, uses_rt_d;
  logic               hazard;
  logic               load_bubble;

  load_use_detect #(.AW(REG_AW)) u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rt_i       (rt_q),
    .id_valid_i    (id_valid_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_uses_rt_i  (id_uses_rt_i),
    .hazard_o      (hazard)
  );

  assign id_ctrl = pack_ctrl(id_reg_write_i, id_alu_op_i, id_alu_src_i, id_reg_dst_i,
                             id_branch_i, id_jump_n_i, id_mem_read_i, id_mem_write_i,
                             id_mem_to_reg_i);

  // Flush and hazard both squash the slot; flush outranks hold.
  assign load_bubble = flush_i || (!hold_i && hazard);
  assign stall_o     = hazard && !flush_i && !hold_i;

  always_comb begin
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    pc4_d     = pc4_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    uses_rt_d = uses_rt_q;
    if (load_bubble) begin
      ctrl_d    = BUBBLE_CTRL;
      valid_d   = 1'b0;
      pc4_d     = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      uses_rt_d = 1'b0;
    end else if (!hold_i) begin
      ctrl_d    = id_valid_i ? id_ctrl : BUBBLE_CTRL;
      valid_d   = id_valid_i;
      pc4_d     = id_pc4_i;
      rs_data_d = id_rs_data_i;
      rt_data_d = id_rt_data_i;
      imm_d     = id_imm_i;
      rs_d      = id_rs_i;
      rt_d      = id_rt_i;
      rd_d      = id_rd_i;
      uses_rt_d = id_uses_rt_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q    <= BUBBLE_CTRL;
      valid_q   <= 1'b0;
      pc4_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      uses_rt_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      pc4_q     <= pc4_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      uses_rt_q <= uses_rt_d;
    end
  end

  assign ex_valid_o      = valid_q;
  assign ex_reg_write_o  = ctrl_q.reg_write;
  assign ex_alu_op_o     = ctrl_q.alu_op;
  assign ex_alu_src_o    = ctrl_q.alu_src;
  assign ex_reg_dst_o    = ctrl_q.reg_dst;
  assign ex_branch_o     = ctrl_q.branch;
  assign ex_jump_n_o     = ctrl_q.jump_n;
  assign ex_mem_read_o   = ctrl_q.mem_read;
  assign ex_mem_write_o  = ctrl_q.mem_write;
  assign ex_mem_to_reg_o = ctrl_q.mem_to_reg;
  assign ex_pc4_o        = pc4_q;
  assign ex_rs_data_o    = rs_data_q;
  assign ex_rt_data_o    = rt_data_q;
  assign ex_imm_o        = imm_q;
  assign ex_rs_o         = rs_q;
  assign ex_rt_o         = rt_q;
  assign ex_rd_o         = rd_q;
  assign ex_uses_rt_o    = uses_rt_q;

`ifdef IDEX_PERF_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (stall_o && (bubble_cnt_q != 16'hFFFF)) bubble_cnt_d = bubble_cnt_q + 16'd1;
    if (flush_i && (flush_cnt_q != 16'hFFFF))  flush_cnt_d  = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register directly downstream of the instruction decoder.
- Each cycle it captures decoded control bits, register-file operands, immediate and register addresses for the EX stage.
- Contains load-use hazard detection: on a hazard it requests an IF/ID + PC stall and inserts a bubble.
- Supports branch/jump flush and a global pipeline hold.

Parameters:
DATA_W, 32, operand/PC width
REG_AW, 5, register address width
ALU_OP_W, 4, decoder ALU opcode width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
hold_i  in  1  global freeze; all EX-side registers keep value
flush_i  in  1  kill the instruction entering EX (taken branch/jump)
id_valid_i  in  1  ID stage holds a real instruction
id_reg_write_i  in  1  decoder RegWrite
id_alu_op_i  in  ALU_OP_W  decoder ALU op
id_alu_src_i  in  1  decoder ALUSrc
id_reg_dst_i  in  1  decoder RegDst
id_branch_i  in  1  decoder Branch
id_jump_n_i  in  1  decoder Jump, active-low (1 = no jump)
id_mem_read_i  in  1  decoder MemRead
id_mem_write_i  in  1  decoder MemWrite
id_mem_to_reg_i  in  1  decoder MemtoReg
id_pc4_i  in  DATA_W  PC+4
id_rs_data_i  in  DATA_W  rs operand
id_rt_data_i  in  DATA_W  rt operand
id_imm_i  in  DATA_W  sign-extended immediate
id_rs_i  in  REG_AW  rs address
id_rt_i  in  REG_AW  rt address
id_rd_i  in  REG_AW  rd address
id_uses_rt_i  in  1  instruction reads rt as source
ex_*_o  out  same as id_* counterpart  registered copies of every id_* input above, including ex_valid_o
stall_o  out  1  hold PC and IF/ID this cycle (combinational)

Behaviour:
- Reset (rst_i low, asynchronous): all ex_* outputs take the bubble value.
  - Bubble value: valid=0, reg_write=0, alu_op=0, alu_src=0, reg_dst=0, branch=0, jump_n=1, mem_read=0, mem_write=0, mem_to_reg=1.
  - All data and address fields are 0.
- Hazard (combinational, from current EX registers and ID inputs):
  - hazard = ex_valid_o & ex_mem_read_o & ex_rt_o!=0 & id_valid_i & (ex_rt_o==id_rs_i | (id_uses_rt_i & ex_rt_o==id_rt_i)).
  - stall_o = hazard & ~flush_i & ~hold_i.
- Per-edge update, priority highest first:
  - flush_i: load bubble, even if hold_i is also asserted.
  - hold_i: keep all registers.
  - hazard: load bubble control and valid=0; data fields don't-care, load 0.
  - otherwise: load all id_* inputs. If id_valid_i=0, load control as bubble but pass data through.
- Latency: exactly 1 cycle ID->EX.
- A load-use pair costs exactly one bubble. On the next cycle EX holds the bubble (mem_read=0), so hazard and stall_o deassert.
- No X propagation: every register has an explicit reset value and an explicit next-state on every path.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined: adds outputs bubble_cnt_o[15:0] and flush_cnt_o[15:0].
  - Each counter increments on every edge where a hazard bubble or a flush (respectively) is loaded.
  - Counters saturate at 16'hFFFF and do not increment while hold_i is high unless flush_i is also high.
  - Reset to 0.
- Undefined: ports and logic are absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - ALU_OP_W, REG_AW, DATA_W.
  - Bubble control constant BUBBLE_CTRL.
  - Packed typedef ctrl_t: reg_write, alu_op, alu_src, reg_dst, branch, jump_n, mem_read, mem_write, mem_to_reg.
- One natural sub-module: load_use_detect, the purely combinational hazard equation, reusable by forwarding logic.

Test Plan:
- Reset: rst_i=0 mid-cycle with ex_reg_write_o=1 -> immediately ex_reg_write_o=0, jump_n=1, mem_to_reg=1, ex_valid_o=0.
- Pass-through: R-type add (alu_op=0, reg_dst=1, reg_write=1, rs=2, rt=3, rd=4) -> identical values on ex_* one edge later; stall_o=0.
- Load-use: lw to rt=5 in EX, ID has add rs=5 -> stall_o=1; next edge ex_valid_o=0, mem_read=0; following cycle stall_o=0 and the add loads.
- Zero-register exception: lw to rt=0 in EX, ID reads rs=0 -> stall_o=0, no bubble.
- Flush vs hold: flush_i=1 and hold_i=1 on the same edge with valid beq in ID -> ex_branch_o=0, ex_valid_o=0. hold_i=1 alone for 3 cycles -> ex_* unchanged and stall_o=0 throughout.
- Perf (IDEX_PERF_CNT_EN): 2 load-use bubbles + 1 flush -> bubble_cnt_o=2, flush_cnt_o=1. Preload 16'hFFFF plus a bubble -> bubble_cnt_o stays 16'hFFFF.
